// File: rtl/npu_act_mem_wr_ctrl.sv
// Write arbiter for the activation BRAM port: hw/host writers share the port with a priority reader.
// Optional build macro ACT_MEM_WR_PROTECT_EN drops hw-side writes below PROT_TOP.
module npu_act_mem_wr_ctrl #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 8,
    parameter int                MEM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0] PROT_TOP  = 12'h400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hw_mem_wr,
    input  logic [ADDR_W-1:0] hw_mem_wr_addr,
    input  logic [DATA_W-1:0] hw_mem_wr_data,
    output logic              hw_mem_wr_ack_p,
    input  logic              host_wr_req,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ack_p,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              cnt_clr,
    output logic [15:0]       wr_cnt,
    output logic              wr_err
);

`ifdef ACT_MEM_WR_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    // Handshake: a requester raises req with stable addr/data and holds it until it
    // sees its one-cycle ack_p; it lowers req the cycle after the ack.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_hw;
    logic              last_hw;
    logic              any_req;
    logic              grant_hw;
    logic              write_cycle;
    logic              out_of_range;
    logic              prot_hit;
    logic              drop;

    assign any_req  = hw_mem_wr | host_wr_req;
    // Round-robin: when both ask, the side not served last wins.
    assign grant_hw = hw_mem_wr & (~host_wr_req | ~last_hw);

    assign out_of_range = (32'(cap_addr) >= 32'(MEM_DEPTH));
    assign prot_hit     = PROT_EN & cap_hw & (cap_addr < PROT_TOP);
    assign drop         = out_of_range | prot_hit;
    assign write_cycle  = (state == S_WR) & ~rd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_WR;
            S_WR:    if (!rd_en) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The reader owns the port whenever it asks; a write only lands on a free WR cycle.
    always_comb begin
        mem_en    = rd_en;
        mem_we    = 1'b0;
        mem_addr  = rd_addr;
        mem_wdata = cap_data;
        if (write_cycle) begin
            mem_en   = 1'b1;
            mem_we   = ~drop;
            mem_addr = cap_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_hw   <= 1'b0;
            last_hw  <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            cap_addr <= grant_hw ? hw_mem_wr_addr : host_wr_addr;
            cap_data <= grant_hw ? hw_mem_wr_data : host_wr_data;
            cap_hw   <= grant_hw;
            last_hw  <= grant_hw;
        end
    end

    // Acks are high exactly during the ACK state, to the granted source only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hw_mem_wr_ack_p <= 1'b0;
            host_wr_ack_p   <= 1'b0;
        end else begin
            hw_mem_wr_ack_p <= write_cycle & cap_hw;
            host_wr_ack_p   <= write_cycle & ~cap_hw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else if (cnt_clr) begin
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else if (write_cycle) begin
            if (drop) begin
                wr_err <= 1'b1;
            end else if (wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

endmodule
